// File: rtl/m7_tx_pkg.sv
// Shared constants for the channel-7 transmit frame sequencer: word width and
// one-hot controller state encodings.
package m7_tx_pkg;

  localparam int WORD_W = 16;
  localparam int ST_W   = 5;

  typedef logic [WORD_W-1:0] word_t;

  localparam logic [ST_W-1:0] ST_IDLE    = 5'b00001;
  localparam logic [ST_W-1:0] ST_PRELOAD = 5'b00010;
  localparam logic [ST_W-1:0] ST_ARM     = 5'b00100;
  localparam logic [ST_W-1:0] ST_SEND    = 5'b01000;
  localparam logic [ST_W-1:0] ST_DRAIN   = 5'b10000;

endpackage

// File: rtl/m7_tx_frame_ctrl_if.sv
// DSP-side and transmitter-side signal bundle of the channel-7 frame sequencer.
// Handshake: fifo_wr pushes dsp_data for each cycle it is high; the FIFO has no
// backpressure, so the DSP watches fifo_count and a push into a full FIFO is lost.
// tx_wren=1 with tx_wr_n=0 for one cycle loads tx_data into the transmitter.
interface m7_tx_frame_ctrl_if
  import m7_tx_pkg::*;
#(
  parameter int FIFO_AW = 4,
  parameter int LEN_W   = 8
);
  logic               fifo_wr;
  word_t              dsp_data;
  logic               fifo_flush;
  logic [LEN_W-1:0]   frame_len;
  logic               start;
  logic               abort;
  logic               load_done_async;
  word_t              tx_data;
  logic               tx_wren;
  logic               tx_wr_n;
  logic               tx_rden;
  logic               busy;
  logic               frame_done;
  logic [FIFO_AW:0]   fifo_count;
  logic               overflow;
  logic               underrun;

  modport master (
    output fifo_wr, dsp_data, fifo_flush, frame_len, start, abort, load_done_async,
    input  tx_data, tx_wren, tx_wr_n, tx_rden, busy, frame_done, fifo_count,
           overflow, underrun
  );

  modport slave (
    input  fifo_wr, dsp_data, fifo_flush, frame_len, start, abort, load_done_async,
    output tx_data, tx_wren, tx_wr_n, tx_rden, busy, frame_done, fifo_count,
           overflow, underrun
  );

endinterface

// File: rtl/m7_tx_fifo.sv
// Synchronous word FIFO with occupancy count. A push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module m7_tx_fifo
  import m7_tx_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic          dsp_clk,
  input  logic          reset_,
  input  logic          push,
  input  word_t         din,
  input  logic          pop,
  input  logic          flush,
  output word_t         head,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          ovf_evt
);

  localparam int DEPTH = 1 << AW;

  word_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign ovf_evt = push && !flush && full && !do_pop;
  assign head    = mem[rd_ptr];

  always_ff @(posedge dsp_clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge dsp_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/m7_tx_frame_ctrl.sv
// Channel-7 transmit frame sequencer: preloads the head word, enables the
// transmitter and refills its data register on each synchronised load_done.
module m7_tx_frame_ctrl
  import m7_tx_pkg::*;
#(
  parameter int FIFO_AW   = 4,
  parameter int LEN_W     = 8,
  parameter int DRAIN_CYC = 64
) (
  input  logic                dsp_clk,
  input  logic                reset_,
  m7_tx_frame_ctrl_if.slave   bus,
  output logic [ST_W-1:0]     state_dbg
);

  localparam int TW = $clog2(DRAIN_CYC + 1);

  logic [ST_W-1:0]  state;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] ld_cnt;
  logic [LEN_W-1:0] ld_k;
  logic [TW-1:0]    drain_tmr;
  logic             ld_s1, ld_s2, ld_s3, ld_edge;
  logic             start_ok, write_now, flush_now;
  logic             tx_wren_r, tx_wr_n_r, tx_rden_r, frame_done_r;
  logic             overflow_r, underrun_r;
  word_t            tx_data_r;
  word_t            fifo_head;
  logic [FIFO_AW:0] fifo_count;
  logic             fifo_empty;
  logic             ovf_evt;

  m7_tx_fifo #(.AW(FIFO_AW)) u_fifo (
    .dsp_clk (dsp_clk),
    .reset_  (reset_),
    .push    (bus.fifo_wr),
    .din     (bus.dsp_data),
    .pop     (write_now),
    .flush   (flush_now),
    .head    (fifo_head),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .ovf_evt (ovf_evt)
  );

  // Two flops resynchronise the clock_57 pulse; the third gives the rising edge,
  // registered so ld_edge is a clean one-cycle strobe three cycles after the rise.
  always_ff @(posedge dsp_clk or negedge reset_) begin
    if (!reset_) begin
      ld_s1   <= 1'b0;
      ld_s2   <= 1'b0;
      ld_s3   <= 1'b0;
      ld_edge <= 1'b0;
    end else begin
      ld_s1   <= bus.load_done_async;
      ld_s2   <= ld_s1;
      ld_s3   <= ld_s2;
      ld_edge <= ld_s2 & ~ld_s3;
    end
  end

  assign ld_k      = ld_cnt + 1'b1;
  assign start_ok  = (state == ST_IDLE) && bus.start && (bus.frame_len != '0) && !fifo_empty;
  assign flush_now = (state == ST_IDLE) && bus.fifo_flush && !start_ok;
  assign write_now = (state == ST_PRELOAD) ||
                     ((state == ST_SEND) && !bus.abort && ld_edge &&
                      (ld_k < len_r) && !fifo_empty);

  always_ff @(posedge dsp_clk or negedge reset_) begin
    if (!reset_) begin
      state        <= ST_IDLE;
      len_r        <= '0;
      ld_cnt       <= '0;
      drain_tmr    <= '0;
      tx_wren_r    <= 1'b0;
      tx_wr_n_r    <= 1'b1;
      tx_data_r    <= '0;
      tx_rden_r    <= 1'b0;
      frame_done_r <= 1'b0;
      overflow_r   <= 1'b0;
      underrun_r   <= 1'b0;
    end else begin
      tx_wren_r    <= write_now;
      tx_wr_n_r    <= !write_now;
      frame_done_r <= 1'b0;
      if (write_now) tx_data_r <= fifo_head;
      if (start_ok) begin
        overflow_r <= 1'b0;
        underrun_r <= 1'b0;
      end
      if (ovf_evt) overflow_r <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            len_r  <= bus.frame_len;
            ld_cnt <= '0;
            state  <= ST_PRELOAD;
          end
        end
        ST_PRELOAD: state <= ST_ARM;
        ST_ARM: begin
          tx_rden_r <= 1'b1;
          state     <= ST_SEND;
        end
        ST_SEND: begin
          // abort outranks a coincident load_done: nothing more is written.
          if (bus.abort) begin
            tx_rden_r <= 1'b0;
            drain_tmr <= '0;
            state     <= ST_DRAIN;
          end else if (ld_edge) begin
            ld_cnt <= ld_k;
            if (ld_k >= len_r) begin
              tx_rden_r <= 1'b0;
              drain_tmr <= '0;
              state     <= ST_DRAIN;
            end else if (fifo_empty) begin
              underrun_r <= 1'b1;
              tx_rden_r  <= 1'b0;
              drain_tmr  <= '0;
              state      <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_tmr == TW'(DRAIN_CYC - 1)) begin
            frame_done_r <= 1'b1;
            state        <= ST_IDLE;
          end else begin
            drain_tmr <= drain_tmr + 1'b1;
          end
        end
        default: begin
          tx_rden_r <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.tx_data    = tx_data_r;
  assign bus.tx_wren    = tx_wren_r;
  assign bus.tx_wr_n    = tx_wr_n_r;
  assign bus.tx_rden    = tx_rden_r;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.frame_done = frame_done_r;
  assign bus.fifo_count = fifo_count;
  assign bus.overflow   = overflow_r;
  assign bus.underrun   = underrun_r;
  assign state_dbg      = state;

endmodule

// File: tb/tb_m7_tx_frame_ctrl.sv
// Directed plus randomized bench for m7_tx_frame_ctrl; expected words and flags
// come from a queue model of the FIFO and the frame-length/underrun rules.
module tb_m7_tx_frame_ctrl;
  import m7_tx_pkg::*;

  localparam int DRAIN_CYC = 64;

  logic            dsp_clk = 1'b0;
  logic            reset_  = 1'b0;
  logic [ST_W-1:0] state_dbg;

  always #5 dsp_clk = ~dsp_clk;

  m7_tx_frame_ctrl_if #(.FIFO_AW(4), .LEN_W(8)) bus ();

  m7_tx_frame_ctrl #(.FIFO_AW(4), .LEN_W(8), .DRAIN_CYC(DRAIN_CYC)) dut (
    .dsp_clk   (dsp_clk),
    .reset_    (reset_),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  int          wr_n_bad    = 0;
  logic [15:0] model_q[$];
  logic [15:0] wr_q[$];
  logic        wr_rden_q[$];

  // Capture every data-register write together with the send enable at that time.
  always @(negedge dsp_clk) begin
    if (bus.tx_wren === 1'b1) begin
      wr_q.push_back(bus.tx_data);
      wr_rden_q.push_back(bus.tx_rden);
      if (bus.tx_wr_n !== 1'b0) wr_n_bad++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge dsp_clk);
  endtask

  task automatic push_word(input logic [15:0] w);
    bus.fifo_wr  = 1'b1;
    bus.dsp_data = w;
    step(1);
    bus.fifo_wr  = 1'b0;
    if (model_q.size() < 16) model_q.push_back(w);
  endtask

  task automatic start_req(input int len);
    bus.frame_len = 8'(len);
    bus.start     = 1'b1;
    step(1);
    bus.start     = 1'b0;
  endtask

  task automatic flush_fifo();
    bus.fifo_flush = 1'b1;
    step(1);
    bus.fifo_flush = 1'b0;
    model_q.delete();
  endtask

  // Load-done pulse; optional abort lands in the cycle the synchronised edge is seen.
  task automatic ld_pulse(input bit with_abort);
    bus.load_done_async = 1'b1;
    step(3);
    if (with_abort) bus.abort = 1'b1;
    step(1);
    bus.abort           = 1'b0;
    bus.load_done_async = 1'b0;
  endtask

  task automatic wait_rden(output bit seen);
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      if (bus.tx_rden === 1'b1) seen = 1'b1;
      else step(1);
    end
  endtask

  task automatic run_frame(input int len, input int abort_ld);
    int          n, term, exp_w;
    bit          seen;
    logic [31:0] obs;
    n = model_q.size();
    wr_q.delete();
    wr_rden_q.delete();
    start_req(len);
    check("busy_after_start", 32'(bus.busy), 32'd1);
    check("overflow_cleared", 32'(bus.overflow), 32'd0);
    wait_rden(seen);
    check("rden_rise", 32'(seen), 32'd1);
    check("head_written_before_rden", 32'(wr_q.size() == 1 && wr_rden_q[0] == 1'b0), 32'd1);
    if (abort_ld != 0) begin
      term  = abort_ld;
      exp_w = (abort_ld < n) ? abort_ld : n;
    end else begin
      term  = (n >= len) ? len : n;
      exp_w = (n >= len) ? len : n;
    end
    for (int k = 1; k <= term; k++) begin
      check("rden_before_ld", 32'(bus.tx_rden), 32'd1);
      ld_pulse(k == abort_ld);
      check("rden_after_ld", 32'(bus.tx_rden), (k == term) ? 32'd0 : 32'd1);
      step(4);
    end
    seen = 1'b0;
    for (int t = 0; t < DRAIN_CYC + 40 && !seen; t++) begin
      step(1);
      if (bus.frame_done === 1'b1) seen = 1'b1;
    end
    check("frame_done", 32'(seen), 32'd1);
    step(1);
    check("busy_after_done", 32'(bus.busy), 32'd0);
    check("write_count", 32'(wr_q.size()), 32'(exp_w));
    for (int i = 0; i < exp_w; i++) begin
      obs = (i < wr_q.size()) ? 32'(wr_q[i]) : 32'hxxxx_xxxx;
      check("tx_word", obs, 32'(model_q[0]));
      if (i > 0 && i < wr_rden_q.size()) check("write_while_rden", 32'(wr_rden_q[i]), 32'd1);
      void'(model_q.pop_front());
    end
    check("underrun_flag", 32'(bus.underrun), (abort_ld == 0 && n < len) ? 32'd1 : 32'd0);
    check("fifo_count_after", 32'(bus.fifo_count), 32'(model_q.size()));
  endtask

  initial begin : main
    bit seen;
    int n, len;
    bus.fifo_wr = 1'b0; bus.dsp_data = '0; bus.fifo_flush = 1'b0; bus.frame_len = '0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.load_done_async = 1'b0;

    // Reset values
    step(3);
    check("rst_tx_rden", 32'(bus.tx_rden), 32'd0);
    check("rst_tx_wr_n", 32'(bus.tx_wr_n), 32'd1);
    check("rst_tx_wren", 32'(bus.tx_wren), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
    check("rst_flags", 32'({bus.overflow, bus.underrun, bus.frame_done}), 32'd0);
    reset_ = 1'b1;
    step(2);

    // Three-word frame
    push_word(16'hA5A5); push_word(16'h0001); push_word(16'hFFFF);
    check("count_3", 32'(bus.fifo_count), 32'd3);
    run_frame(3, 0);

    // Underrun: four words requested, two available
    push_word(16'($urandom)); push_word(16'($urandom));
    run_frame(4, 0);
    step(3);
    check("underrun_sticky", 32'(bus.underrun), 32'd1);

    // Ignored starts: empty FIFO, then zero length
    wr_q.delete();
    start_req(3);
    step(4);
    check("empty_start_busy", 32'(bus.busy), 32'd0);
    push_word(16'h1234);
    start_req(0);
    step(4);
    check("len0_start_busy", 32'(bus.busy), 32'd0);
    check("ignored_no_writes", 32'(wr_q.size()), 32'd0);
    check("ignored_keeps_underrun", 32'(bus.underrun), 32'd1);
    flush_fifo();
    check("flush_count", 32'(bus.fifo_count), 32'd0);

    // Overflow: 17 pushes into an empty FIFO
    for (int i = 0; i < 17; i++) push_word(16'($urandom));
    check("ovf_count", 32'(bus.fifo_count), 32'd16);
    check("ovf_flag", 32'(bus.overflow), 32'd1);
    run_frame(16, 0);

    // Abort coinciding with the second load_done
    for (int i = 0; i < 5; i++) push_word(16'($urandom));
    run_frame(5, 2);

    // Randomized frames
    for (int r = 0; r < 6; r++) begin
      flush_fifo();
      n   = $urandom_range(1, 8);
      len = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) push_word(16'($urandom));
      run_frame(len, 0);
    end

    // Asynchronous reset while sending
    flush_fifo();
    for (int i = 0; i < 3; i++) push_word(16'($urandom));
    start_req(3);
    wait_rden(seen);
    check("pre_reset_rden", 32'(seen), 32'd1);
    #2 reset_ = 1'b0;
    #1;
    check("async_rst_rden", 32'(bus.tx_rden), 32'd0);
    check("async_rst_wr_n", 32'(bus.tx_wr_n), 32'd1);
    check("async_rst_count", 32'(bus.fifo_count), 32'd0);
    model_q.delete();
    step(2);
    reset_ = 1'b1;
    step(2);
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    check("wr_n_with_wren", 32'(wr_n_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
